if_fetch_req: RTL and testbench

Fetch-side request engine for the instruction-memory port: generates word-aligned instruction addresses, drives the request/grant/rvalid handshake toward instruction memory, and buffers returned words in order for the fetch stage. It sits between the program counter logic and the instruction memory. It is the initiator that feeds the capture register on the fetch/memory boundary. Branch redirects flush buffered and in-flight words. At most two transactions are in flight.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fetch_fifo.sv | 66 ++++++
 rtl/if_fetch_req.sv | 154 +++++++++++++++
 tb/tb_if_fetch_req.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch request engine.
package if_pkg;

  localparam int unsigned XLen       = 32;
  localparam int unsigned FetchDepth = 2;
  localparam int unsigned CntW       = 2;
  localparam logic [XLen-1:0] BootAddr = 32'h0000_0080;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry FIFO whose head is held in its own register, so the head
// fields can drive module outputs without a read multiplexer.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter type T = fetch_entry_t
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  T                data_i,
  input  logic            pop_i,
  output T                data_o,
  output logic [CntW-1:0] count_o
);

  T                head_q, head_d;
  T                tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push;
  logic            do_pop;

  // Next-state for head/tail/count; a push into a full FIFO is only taken
  // when a pop frees a slot in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q < CntW'(FetchDepth)) || do_pop);
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == '0) begin
        if (do_push) head_d = data_i;
      end else if (cnt_q == CntW'(1)) begin
        if (do_push && do_pop) head_d = data_i;
        else if (do_push)      tail_d = data_i;
      end else begin
        if (do_pop) begin
          head_d = tail_q;
          if (do_push) tail_d = data_i;
        end
      end
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_req.sv
// Instruction-fetch request engine: issues word addresses on the
// req/gnt/rvalid port, tracks in-flight requests and buffers returned
// words in order for the fetch stage; branches flush and discard.
module if_fetch_req
  import if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     instr_addr_q, instr_addr_d;
  logic [31:0]     next_addr_q, next_addr_d;
  logic [CntW-1:0] disc_q, disc_d;
  logic            busy_q, busy_d;

  logic [CntW-1:0] out_cnt;
  logic [CntW-1:0] fifo_cnt;
  logic [CntW-1:0] out_nxt;
  logic [CntW-1:0] fifo_nxt;
  logic            gnt;
  logic            rsp;
  logic            drop;
  logic            push;
  logic            pop;
  logic            issue;
  logic            credit_ok;
  logic [31:0]     tgt_addr;
  logic [31:0]     issue_addr;
  logic [31:0]     rsp_addr;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Handshake decode, counters, credit and FSM next state.
  always_comb begin
    state_d      = state_q;
    instr_addr_d = instr_addr_q;
    next_addr_d  = next_addr_q;
    disc_d       = disc_q;
    issue        = 1'b0;

    tgt_addr   = branch_addr_i & ~32'h3;
    gnt        = (state_q == REQ) && instr_gnt_i;
    // Responses with nothing in flight (e.g. after reset) are ignored.
    rsp        = instr_rvalid_i && (out_cnt != '0);
    drop       = rsp && (disc_q != '0);
    push       = rsp && !drop && !branch_i;
    pop        = valid_o && ready_i && !branch_i;
    out_nxt    = out_cnt + CntW'(gnt) - CntW'(rsp);
    fifo_nxt   = branch_i ? '0 : (fifo_cnt + CntW'(push) - CntW'(pop));
    credit_ok  = (({1'b0, out_nxt} + {1'b0, fifo_nxt}) < 3'(FetchDepth));
    issue_addr = branch_i ? tgt_addr : next_addr_q;

    push_entry.addr  = rsp_addr;
    push_entry.rdata = instr_rdata_i;
    push_entry.err   = instr_err_i;

    // A request still waiting for its grant is stale too and must be dropped.
    if (branch_i) begin
      disc_d = out_nxt + CntW'((state_q == REQ) && !instr_gnt_i);
    end else if (drop) begin
      disc_d = disc_q - CntW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fetch_en_i && credit_ok) begin
          state_d = REQ;
          issue   = 1'b1;
        end
      end
      REQ: begin
        if (instr_gnt_i) begin
          if (fetch_en_i && credit_ok) issue = 1'b1;
          else                         state_d = IDLE;
        end
      end
    endcase

    if (issue) begin
      instr_addr_d = issue_addr;
      next_addr_d  = issue_addr + 32'd4;
    end else if (branch_i) begin
      next_addr_d = tgt_addr;
    end

    busy_d = (state_d == REQ) || (out_nxt != '0) || (fifo_nxt != '0);
  end

  // Control and address registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      instr_addr_q <= BootAddr;
      next_addr_q  <= BootAddr;
      disc_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_addr_q <= instr_addr_d;
      next_addr_q  <= next_addr_d;
      disc_q       <= disc_d;
      busy_q       <= busy_d;
    end
  end

  // In-flight address queue; its occupancy is the outstanding count.
  if_fetch_fifo #(.T(logic [31:0])) u_addr_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (gnt),
    .data_i  (instr_addr_q),
    .pop_i   (rsp),
    .data_o  (rsp_addr),
    .count_o (out_cnt)
  );

  // Returned-word buffer toward the fetch stage.
  if_fetch_fifo #(.T(fetch_entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (branch_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_cnt)
  );

  assign instr_req_o  = (state_q == REQ);
  assign instr_addr_o = instr_addr_q;
  assign busy_o       = busy_q;
  assign valid_o      = (fifo_cnt != '0);
  assign rdata_o      = head_entry.rdata;
  assign addr_o       = head_entry.addr;
  assign err_o        = head_entry.err;

endmodule

// File: tb/tb_if_fetch_req.sv
// Directed bench for if_fetch_req with an in-order memory responder.
module tb_if_fetch_req;
  import if_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        fetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        busy_o;

  localparam logic [31:0] Pat = 32'hA5A5_0000;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          ovf_cnt   = 0;
  logic        gnt_en;
  logic        rsp_en;
  logic [31:0] err_addr;
  logic [31:0] pend[$];
  logic [31:0] grant_log[$];
  fetch_entry_t pop_log[$];

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic        gnt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_addr_o;
    logic        e_busy;
  } vec_t;
  vec_t tbl[11];

  if_fetch_req dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .fetch_en_i     (fetch_en_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] gget(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic fetch_entry_t pget(input int i);
    fetch_entry_t e;
    e = '{addr: 32'hDEAD_BEEF, rdata: 32'hDEAD_BEEF, err: 1'b1};
    if (i < pop_log.size()) e = pop_log[i];
    return e;
  endfunction

  // Called just after a negedge: drive memory side for this cycle, log
  // grants and pops that the next posedge will perform, advance one cycle.
  task automatic step();
    logic [31:0] a;
    instr_gnt_i = gnt_en;
    if (rsp_en && pend.size() > 0) begin
      a              = pend.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = a ^ Pat;
      instr_err_i    = (a == err_addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      instr_err_i    = 1'b0;
    end
    if (rst_ni && instr_req_o && instr_gnt_i) begin
      pend.push_back(instr_addr_o);
      grant_log.push_back(instr_addr_o);
    end
    if (rst_ni && valid_o && ready_i && !branch_i)
      pop_log.push_back('{addr: addr_o, rdata: rdata_o, err: err_o});
    if (instr_rvalid_i && dut.fifo_cnt == 2'd2) ovf_cnt++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    pop_log.delete();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; fetch_en_i = 1'b0; ready_i = 1'b0; branch_i = 1'b0;
    gnt_en = 1'b0; rsp_en = 1'b0;
    step();
    pend.delete();
    clear_logs();
    rst_ni = 1'b1;
  endtask

  task automatic run_until_pops(input int n, input int limit, input string nm);
    int c = 0;
    while (pop_log.size() < n && c < limit) begin
      step();
      c++;
    end
    chk({nm, "_timeout"}, 32'(pop_log.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_req"},   32'(instr_req_o), 32'd0);
    chk({nm, "_iaddr"}, instr_addr_o,     32'h80);
    chk({nm, "_valid"}, 32'(valid_o),     32'd0);
    chk({nm, "_rdata"}, rdata_o,          32'd0);
    chk({nm, "_addr"},  addr_o,           32'd0);
    chk({nm, "_err"},   32'(err_o),       32'd0);
    chk({nm, "_busy"},  32'(busy_o),      32'd0);
  endtask

  initial begin
    fetch_entry_t e;
    int c;
    rst_ni = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    instr_rdata_i = 32'h0; instr_err_i = 1'b0;
    gnt_en = 1'b0; rsp_en = 1'b1; err_addr = 32'hFFFF_FFFF;

    // rst, en, rdy, gnt | req, instr_addr, valid, addr_o, busy
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 1'b0, 32'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h00, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h84, 1'b0, 32'h00, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h84, 1'b1, 32'h80, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h88, 1'b1, 32'h84, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8C, 1'b0, 32'h00, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8C, 1'b1, 32'h88, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h90, 1'b1, 32'h8C, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h90, 1'b0, 32'h00, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h90, 1'b1, 32'h90, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h90, 1'b0, 32'h00, 1'b0};

    @(negedge clk);

    // Cycle-exact stream from reset with one-cycle memory latency.
    for (int i = 0; i < 11; i++) begin
      rst_ni = tbl[i].rst_n; fetch_en_i = tbl[i].en;
      ready_i = tbl[i].rdy;  gnt_en = tbl[i].gnt;
      step();
      chk($sformatf("row%0d_req", i),   32'(instr_req_o), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_iaddr", i), instr_addr_o,     tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), 32'(valid_o),     32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("row%0d_addr_o", i), addr_o, tbl[i].e_addr_o);
      chk($sformatf("row%0d_busy", i),  32'(busy_o),      32'(tbl[i].e_busy));
      if (i == 0) begin
        chk("row0_rdata", rdata_o, 32'd0);
        chk("row0_err", 32'(err_o), 32'd0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      e = pget(i);
      chk($sformatf("stream_pop%0d_addr", i),  e.addr,  32'h80 + 32'(4 * i));
      chk($sformatf("stream_pop%0d_rdata", i), e.rdata, (32'h80 + 32'(4 * i)) ^ Pat);
    end

    // Backpressure: credit limits to two grants, then resume at 0x88.
    do_reset();
    fetch_en_i = 1'b1; ready_i = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (8) step();
    chk("bp_grants", 32'(grant_log.size()), 32'd2);
    chk("bp_req", 32'(instr_req_o), 32'd0);
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_valid", 32'(valid_o), 32'd1);
    chk("bp_head_addr", addr_o, 32'h80);
    chk("bp_head_rdata", rdata_o, 32'h80 ^ Pat);
    ready_i = 1'b1;
    c = 0;
    while (grant_log.size() < 3 && c < 20) begin step(); c++; end
    chk("bp_resume_addr", gget(2), 32'h88);
    run_until_pops(3, 20, "bp_pops");
    chk("bp_pop1_addr", pget(1).addr, 32'h84);
    chk("bp_pop2_addr", pget(2).addr, 32'h88);

    // Branch with two requests in flight: both responses dropped.
    do_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
    repeat (3) step();
    chk("br2_busy", 32'(busy_o), 32'd1);
    clear_logs();
    branch_addr_i = 32'h1003; branch_i = 1'b1;
    step();
    branch_i = 1'b0; rsp_en = 1'b1;
    run_until_pops(2, 40, "br2_pops");
    chk("br2_first_grant", gget(0), 32'h1000);
    chk("br2_pop0_addr", pget(0).addr, 32'h1000);
    chk("br2_pop0_rdata", pget(0).rdata, 32'h1000 ^ Pat);
    chk("br2_pop1_addr", pget(1).addr, 32'h1004);

    // Branch while a request waits for grant: request held, then dropped.
    do_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (2) step();
    chk("brh_pre_addr", instr_addr_o, 32'h84);
    clear_logs();
    gnt_en = 1'b0; branch_addr_i = 32'h2000; branch_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      branch_i = 1'b0;
      chk($sformatf("brh_hold%0d_req", k),  32'(instr_req_o), 32'd1);
      chk($sformatf("brh_hold%0d_addr", k), instr_addr_o,     32'h84);
    end
    gnt_en = 1'b1;
    run_until_pops(1, 40, "brh_pops");
    chk("brh_grant0", gget(0), 32'h84);
    chk("brh_grant1", gget(1), 32'h2000);
    chk("brh_pop0_addr", pget(0).addr, 32'h2000);

    // Bus error is reported with its word; fetching continues.
    do_reset();
    err_addr = 32'h84;
    fetch_en_i = 1'b1; ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
    run_until_pops(3, 40, "err_pops");
    chk("err_pop0_err", 32'(pget(0).err), 32'd0);
    chk("err_pop1_addr", pget(1).addr, 32'h84);
    chk("err_pop1_err", 32'(pget(1).err), 32'd1);
    chk("err_pop2_addr", pget(2).addr, 32'h88);
    chk("err_pop2_err", 32'(pget(2).err), 32'd0);
    chk("err_pop2_rdata", pget(2).rdata, 32'h88 ^ Pat);
    err_addr = 32'hFFFF_FFFF;

    // Reset mid-stream with two in flight, then restart from BootAddr.
    do_reset();
    fetch_en_i = 1'b1; ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0;
    repeat (3) step();
    chk("rst_mid_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0; gnt_en = 1'b0;
    step();
    check_reset_outputs("rst_mid");
    pend.delete();
    clear_logs();
    rst_ni = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1;
    run_until_pops(1, 40, "rst_pops");
    chk("rst_first_grant", gget(0), 32'h80);
    chk("rst_pop0_addr", pget(0).addr, 32'h80);

    chk("no_rvalid_when_full", 32'(ovf_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
